// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
//   tx_state_t : transmitter FSM state encoding
//   DATA_BITS  : payload bits per frame
//   IDLE_LVL   : line level for idle and stop bits
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } tx_state_t;

  localparam int unsigned DATA_BITS = 8;
  localparam logic        IDLE_LVL  = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 and wraps; o_tick is high for the single cycle
// in which the counter sits at its last value, so the owner advances on the wrap.
// Ports:
//   clk     : clock, posedge
//   rst     : asynchronous reset, active-high
//   i_clear : hold the counter at zero (no ticks while asserted)
//   o_tick  : one-cycle pulse on wrap
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == LAST);
  assign o_tick = w_wrap && !i_clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Read-side consumer of the 8-entry byte FIFO: pops one byte at a time and
// sends it on txd as an 8N1 frame, LSB first. Back-to-back frames are sent
// without an idle gap while the FIFO stays non-empty.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit after DATA.
// Ports:
//   clk        : clock, posedge
//   rst        : asynchronous reset, active-high
//   fifo_out   : FIFO read data (valid on the posedge after the fifo_re pulse)
//   fifo_empty : FIFO empty flag
//   fifo_re    : FIFO read enable, one-cycle pulse (registered)
//   txd        : serial output, idles high (registered)
//   busy       : high from FETCH through the last stop-bit cycle (registered)
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] fifo_out,
  input  logic       fifo_empty,
  output logic       fifo_re,
  output logic       txd,
  output logic       busy
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_t  r_state;
  logic [7:0] r_shift;
  logic [2:0] r_bit;
  logic       r_re;
  logic       r_txd;
  logic       r_busy;
  logic       w_tick;
  logic       w_clear;
`ifdef UART_TX_PARITY_EN
  logic       r_par;
`endif

  // Hold the bit timer at zero until the frame starts so START gets a full period.
  assign w_clear = (r_state == IDLE) || (r_state == FETCH);

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_re    <= 1'b0;
      r_txd   <= IDLE_LVL;
      r_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_re <= 1'b0;
      case (r_state)
        IDLE: begin
          r_txd <= IDLE_LVL;
          if (!fifo_empty) begin
            r_re    <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= FETCH;
          end
        end
        FETCH: begin
          // FIFO zeroes its output on the next negedge; this is the only capture point.
          r_shift <= fifo_out;
`ifdef UART_TX_PARITY_EN
          r_par   <= ^fifo_out;
`endif
          r_txd   <= 1'b0;
          r_state <= START;
        end
        START: begin
          if (w_tick) begin
            r_txd   <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
            r_bit   <= '0;
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_tick) begin
            r_bit <= r_bit + 3'd1;
            if (r_bit == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              r_txd   <= r_par;
              r_state <= PARITY;
`else
              r_txd   <= IDLE_LVL;
              r_state <= STOP;
`endif
            end else begin
              r_txd   <= r_shift[0];
              r_shift <= {1'b0, r_shift[7:1]};
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_tick) begin
            r_txd   <= IDLE_LVL;
            r_state <= STOP;
          end
        end
`endif
        STOP: begin
          if (w_tick) begin
            if (!fifo_empty) begin
              r_re    <= 1'b1;
              r_state <= FETCH;
            end else begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_txd   <= IDLE_LVL;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign fifo_re = r_re;
  assign txd     = r_txd;
  assign busy    = r_busy;

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk        = 1'b0;
  logic       rst        = 1'b1;
  logic [7:0] fifo_out   = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       fifo_re;
  logic       txd;
  logic       busy;

  logic [7:0] fq[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .CLKS_PER_BIT (4),
    .CNT_W        (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_out   (fifo_out),
    .fifo_empty (fifo_empty),
    .fifo_re    (fifo_re),
    .txd        (txd),
    .busy       (busy)
  );

  // FIFO read side: output registered on negedge, zeroed when not read.
  always @(negedge clk) begin
    if (fifo_re === 1'b1 && fq.size() > 0) fifo_out <= fq.pop_front();
    else                                    fifo_out <= 8'h00;
    fifo_empty = (fq.size() == 0);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    fifo_empty = 1'b0;
  endtask

  function automatic logic [NB-1:0] exp_frame(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction

  // Waits (bounded) for a fifo_re pulse; cyc = cycles taken, 99 on timeout.
  task automatic wait_re(output int cyc);
    cyc = 99;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (fifo_re === 1'b1) begin
        cyc = k;
        break;
      end
    end
  endtask

  // Samples one frame (4 cycles per bit) starting on the cycle after the re pulse.
  // clean=0 if a bit changed inside its period, busy dropped or fifo_re rose.
  task automatic capture_frame(input int push_at, input logic [7:0] pb,
                               output logic [NB-1:0] bits, output bit clean);
    int n;
    n = 0;
    clean = 1'b1;
    bits = '0;
    for (int i = 0; i < NB; i++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        if (n == push_at) push(pb);
        n++;
        if (c == 0) bits[i] = txd;
        else if (txd !== bits[i]) clean = 1'b0;
        if (busy !== 1'b1 || fifo_re !== 1'b0) clean = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    rst = 1'b1;
    repeat (3) step();
    n_checks++; if (txd !== 1'b1)     begin n_fail++; $display("FAIL reset_txd: got %b expected 1", txd); end
    n_checks++; if (fifo_re !== 1'b0) begin n_fail++; $display("FAIL reset_re: got %b expected 0", fifo_re); end
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    ok = 1'b1;
    repeat (6) begin
      step();
      if (txd !== 1'b1 || fifo_re !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL reset_idle_hold: got txd=%b re=%b busy=%b expected 1/0/0", txd, fifo_re, busy); end
  endtask

  task automatic test_single();
    int cyc;
    logic [NB-1:0] bits;
    bit clean, ok;
    push(8'hA5);
    wait_re(cyc);
    n_checks++; if (cyc !== 1) begin n_fail++; $display("FAIL single_re_latency: got %0d expected 1", cyc); end
    n_checks++; if (busy !== 1'b1 || txd !== 1'b1) begin n_fail++; $display("FAIL single_fetch: got busy=%b txd=%b expected 1/1", busy, txd); end
    capture_frame(-1, 8'h00, bits, clean);
`ifndef UART_TX_PARITY_EN
    n_checks++; if (bits !== 10'b1101001010) begin n_fail++; $display("FAIL single_frame: got %b expected %b", bits, 10'b1101001010); end
`else
    n_checks++; if (bits !== exp_frame(8'hA5)) begin n_fail++; $display("FAIL single_frame: got %b expected %b", bits, exp_frame(8'hA5)); end
`endif
    n_checks++; if (!clean) begin n_fail++; $display("FAIL single_stable: got 0 expected 1"); end
    step();
    n_checks++; if (busy !== 1'b0 || txd !== 1'b1 || fifo_re !== 1'b0) begin n_fail++; $display("FAIL single_end: got busy=%b txd=%b re=%b expected 0/1/0", busy, txd, fifo_re); end
    ok = 1'b1;
    repeat (8) begin
      step();
      if (fifo_re !== 1'b0 || txd !== 1'b1) ok = 1'b0;
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_idle_after: got re=%b txd=%b expected 0/1", fifo_re, txd); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] tbl [3];
    logic [NB-1:0] bits;
    int cyc, pulses;
    bit clean;
    tbl[0] = 8'h01; tbl[1] = 8'h80; tbl[2] = 8'hFF;
    for (int k = 0; k < 3; k++) push(tbl[k]);
    wait_re(cyc);
    pulses = (cyc != 99) ? 1 : 0;
    for (int k = 0; k < 3; k++) begin
      capture_frame(-1, 8'h00, bits, clean);
      n_checks++; if (bits !== exp_frame(tbl[k])) begin n_fail++; $display("FAIL b2b_frame%0d: got %b expected %b", k, bits, exp_frame(tbl[k])); end
      n_checks++; if (bits[8:1] !== tbl[k]) begin n_fail++; $display("FAIL b2b_byte%0d: got %h expected %h", k, bits[8:1], tbl[k]); end
      n_checks++; if (!clean) begin n_fail++; $display("FAIL b2b_stable%0d: got 0 expected 1", k); end
      step();
      if (fifo_re === 1'b1) pulses++;
      if (k < 2) begin
        n_checks++; if (fifo_re !== 1'b1 || txd !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_nogap%0d: got re=%b txd=%b busy=%b expected 1/1/1", k, fifo_re, txd, busy); end
      end else begin
        n_checks++; if (fifo_re !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got re=%b busy=%b expected 0/0", fifo_re, busy); end
      end
    end
    repeat (6) begin
      step();
      if (fifo_re === 1'b1) pulses++;
    end
    n_checks++; if (pulses !== 3) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 3", pulses); end
  endtask

  task automatic test_reset_midframe();
    int cyc;
    bit ok;
    push(8'h3C);
    wait_re(cyc);
    repeat (14) step();
    n_checks++; if (busy !== 1'b1 || txd !== 1'b1) begin n_fail++; $display("FAIL abort_pre: got busy=%b txd=%b expected 1/1", busy, txd); end
    rst = 1'b1;
    #1;
    n_checks++; if (txd !== 1'b1 || busy !== 1'b0 || fifo_re !== 1'b0) begin n_fail++; $display("FAIL abort_async: got txd=%b busy=%b re=%b expected 1/0/0", txd, busy, fifo_re); end
    repeat (2) step();
    rst = 1'b0;
    ok = 1'b1;
    repeat (50) begin
      step();
      if (fifo_re !== 1'b0 || txd !== 1'b1 || busy !== 1'b0) ok = 1'b0;
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL abort_no_reread: got re=%b txd=%b busy=%b expected 0/1/0", fifo_re, txd, busy); end
  endtask

  task automatic test_drain_in_stop();
    int cyc;
    logic [NB-1:0] bits;
    bit clean, ok;
    push(8'h5A);
    wait_re(cyc);
    // Second byte arrives mid-DATA; it must wait for the last STOP cycle.
    capture_frame(10, 8'hC3, bits, clean);
    n_checks++; if (bits !== exp_frame(8'h5A) || !clean) begin n_fail++; $display("FAIL drain_frame0: got %b clean=%b expected %b clean=1", bits, clean, exp_frame(8'h5A)); end
    step();
    n_checks++; if (fifo_re !== 1'b1) begin n_fail++; $display("FAIL drain_b2b_re: got %b expected 1", fifo_re); end
    capture_frame(-1, 8'h00, bits, clean);
    n_checks++; if (bits !== exp_frame(8'hC3) || !clean) begin n_fail++; $display("FAIL drain_frame1: got %b clean=%b expected %b clean=1", bits, clean, exp_frame(8'hC3)); end
    step();
    n_checks++; if (fifo_re !== 1'b0 || busy !== 1'b0 || fifo_empty !== 1'b1) begin n_fail++; $display("FAIL drain_idle: got re=%b busy=%b empty=%b expected 0/0/1", fifo_re, busy, fifo_empty); end
    ok = 1'b1;
    repeat (10) begin
      step();
      if (fifo_re !== 1'b0 || txd !== 1'b1) ok = 1'b0;
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL drain_stay_idle: got re=%b txd=%b expected 0/1", fifo_re, txd); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int cyc;
    logic [NB-1:0] bits;
    bit clean;
    push(8'h07);
    wait_re(cyc);
    capture_frame(-1, 8'h00, bits, clean);
    n_checks++; if (bits !== 11'b11000001110) begin n_fail++; $display("FAIL parity_frame: got %b expected %b", bits, 11'b11000001110); end
    n_checks++; if (!clean) begin n_fail++; $display("FAIL parity_len44: got unstable expected 44 busy cycles"); end
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL parity_end: got busy=%b expected 0", busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_midframe();
    test_drain_in_stop();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
